i2s_stereo_fifo: RTL and testbench
==================================

Name: i2s_stereo_fifo

Overview:
- Downstream stage of the I2S microphone receiver.
- Takes the single-channel sample stream (one word per word-select half-period, tagged with channel) and pairs left and right words into stereo frames.
- Buffers frames in a show-ahead FIFO and presents them on a valid/ready interface to the consumer (SPI readout or audio processing).
- Detects pairing errors and overflow.

Parameters:
- DATA_SIZE, 16, sample width in bits; legal values 8, 16, 24, 32.
- DEPTH, 16, FIFO depth in stereo frames; power of two, minimum 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sample_valid  input  1  one-cycle strobe: sample_data/sample_ch are valid this cycle.
- sample_data  input  DATA_SIZE  received audio word.
- sample_ch  input  1  channel of the word: 0 = left (ws low), 1 = right (ws high).
- frame_valid  output  1  FIFO non-empty; frame_left/frame_right are valid.
- frame_ready  input  1  consumer accepts the frame when frame_valid & frame_ready.
- frame_left  output  DATA_SIZE  left word of the head frame.
- frame_right  output  DATA_SIZE  right word of the head frame.
- level  output  $clog2(DEPTH)+1  number of frames stored.
- overflow  output  1  sticky: a completed frame was dropped because the FIFO was full.
- sync_err  output  1  sticky: a left/right pairing violation occurred.
- clear_flags  input  1  one-cycle pulse; clears overflow and sync_err.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Outputs: frame_valid=0, level=0, overflow=0, sync_err=0.
  - Internal state: pointers=0, pairing state=IDLE, holding register=0.
  - frame_left/frame_right are don't-care while frame_valid=0.
  - Reset mid-operation discards all stored frames and any held left word.
- Pairing FSM, two states:
  - IDLE:
    - sample_valid & ch=0: store the word in the left holding register, go to HAVE_L.
    - sample_valid & ch=1: drop the word, set sync_err, stay in IDLE.
  - HAVE_L:
    - sample_valid & ch=1: form the frame {held left, sample_data}, issue a push, go to IDLE.
    - sample_valid & ch=0: replace the held left word with the new one, set sync_err, stay in HAVE_L.
  - sample_valid=0: no state change.
- FIFO:
  - Circular buffer with DEPTH entries. Read/write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. level is kept as a separate counter.
  - Pop occurs when frame_valid & frame_ready.
  - Push is accepted when level<DEPTH, or when a pop occurs in the same cycle.
  - Push when level==DEPTH with no pop: the frame is dropped, overflow is set, and the FIFO is unchanged.
  - Simultaneous accepted push and pop: level unchanged; both pointers advance.
  - Pop with level==0 cannot occur (frame_valid=0).
  - Show-ahead: frame_left/frame_right always reflect the entry at the read pointer.
- Latency: a frame pushed at edge N is visible with frame_valid=1 after edge N; frame_valid and level are registered.
- Status flags:
  - frame_valid = (level != 0), registered.
  - clear_flags clears both flags. If a set event happens in the same cycle as clear_flags, set wins.
  - Flags are independent of frame_ready.
- Consumer stall: frame_ready may stay low indefinitely. Frames accumulate to DEPTH, then overflow.
- No combinational path from frame_ready to any output.

Test Plan:
- Basic pair: after reset, L=0x1234 then R=0xABCD (strobes 4 cycles apart), frame_ready=0 -> next cycle frame_valid=1, frame_left=0x1234, frame_right=0xABCD, level=1; pulse frame_ready -> level=0, frame_valid=0.
- Fill/overflow (DEPTH=16): push 17 frames with L=k, R=0x100+k (k=0..16), no reads -> level=16, overflow=1 after frame 16 is dropped; drain -> frames 0..15 in order, last frame_right=0x10F, then frame_valid=0.
- Pairing errors: R first (0x5555) -> sync_err=1, no frame. Then L=0x0001, L=0x0002, R=0x0003 -> exactly one frame {0x0002,0x0003}. clear_flags -> sync_err=0.
- Full with simultaneous pop: level=16 and frame_ready=1 in the same cycle as a completing R -> frame accepted, level stays 16, overflow stays 0, head advances by one.
- Wrap-around: 40 frames streamed with frame_ready=1 continuously -> every frame output in order with correct L/R values, level never exceeds 1, no flags set.
- Reset mid-operation: level=5 and FSM in HAVE_L, assert rst one cycle -> level=0, frame_valid=0, flags=0. A following R word sets sync_err (held left was discarded).

Source files
------------

// File: rtl/i2s_stereo_fifo.sv
// Pairs left/right I2S words into stereo frames and buffers them in a show-ahead
// FIFO with sticky pairing-error and overflow flags.
module i2s_stereo_fifo #(
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_valid,
  input  logic [DATA_SIZE-1:0]       sample_data,
  input  logic                       sample_ch,
  output logic                       frame_valid,
  input  logic                       frame_ready,
  output logic [DATA_SIZE-1:0]       frame_left,
  output logic [DATA_SIZE-1:0]       frame_right,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       sync_err,
  input  logic                       clear_flags,
  output logic                       pair_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic {IDLE = 1'b0, HAVE_L = 1'b1} pair_t;

  pair_t                  state;
  logic [DATA_SIZE-1:0]   hold_l;
  logic [2*DATA_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;

  logic          push;
  logic          push_ok;
  logic          pop;
  logic          sync_set;
  logic          ovf_set;
  logic [LW-1:0] level_nxt;

  // Consumer handshake: a frame transfers on any rising edge where frame_valid
  // and frame_ready are both high; frame_valid never depends on frame_ready.
  assign pop = frame_valid & frame_ready;

  always_comb begin
    push      = 1'b0;
    sync_set  = 1'b0;
    push_ok   = 1'b0;
    ovf_set   = 1'b0;
    level_nxt = level;
    if (sample_valid) begin
      push     = (state == HAVE_L) & sample_ch;
      sync_set = (state == IDLE) ? sample_ch : ~sample_ch;
    end
    // A pop in the same cycle frees the slot a full FIFO would otherwise lack.
    push_ok = push & ((level != FULL) | pop);
    ovf_set = push & ~push_ok;
    if (push_ok & ~pop)      level_nxt = level + LW'(1);
    else if (~push_ok & pop) level_nxt = level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_l      <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      frame_valid <= 1'b0;
      overflow    <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      if (sample_valid) begin
        if (!sample_ch) begin
          hold_l <= sample_data;
          state  <= HAVE_L;
        end else begin
          state  <= IDLE;
        end
      end
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      frame_valid <= (level_nxt != '0);
      if (sync_set)         sync_err <= 1'b1;
      else if (clear_flags) sync_err <= 1'b0;
      if (ovf_set)          overflow <= 1'b1;
      else if (clear_flags) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {hold_l, sample_data};
  end

  assign frame_left  = mem[rd_ptr][2*DATA_SIZE-1:DATA_SIZE];
  assign frame_right = mem[rd_ptr][DATA_SIZE-1:0];
  assign pair_state  = state;

endmodule

// File: tb/tb_i2s_stereo_fifo.sv
// Bench for i2s_stereo_fifo: table vectors, directed corner sequences and random
// traffic, all checked against a queue-based frame model.
module tb_i2s_stereo_fifo;

  localparam int DS = 16;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DS-1:0] sample_data = '0;
  logic          sample_ch = 1'b0;
  logic          frame_valid;
  logic          frame_ready = 1'b0;
  logic [DS-1:0] frame_left;
  logic [DS-1:0] frame_right;
  logic [4:0]    level;
  logic          overflow;
  logic          sync_err;
  logic          clear_flags = 1'b0;
  logic          pair_state;

  i2s_stereo_fifo #(.DATA_SIZE(DS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_ch(sample_ch), .frame_valid(frame_valid), .frame_ready(frame_ready),
    .frame_left(frame_left), .frame_right(frame_right), .level(level),
    .overflow(overflow), .sync_err(sync_err), .clear_flags(clear_flags),
    .pair_state(pair_state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: stored frames as a queue, plus the pending left word.
  logic [2*DS-1:0] exp_q[$];
  logic            m_have_l;
  logic [DS-1:0]   m_left;
  logic            m_ovf;
  logic            m_sync;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_have_l = 1'b0;
    m_left   = '0;
    m_ovf    = 1'b0;
    m_sync   = 1'b0;
  endfunction

  // Applies the inputs present at this clock edge to the model.
  function automatic void model_step();
    bit do_pop, full, set_sync, set_ovf;
    do_pop   = (exp_q.size() != 0) && frame_ready;
    full     = (exp_q.size() == DEPTH);
    set_sync = 1'b0;
    set_ovf  = 1'b0;
    if (do_pop) void'(exp_q.pop_front());
    if (sample_valid) begin
      if (!sample_ch) begin
        if (m_have_l) set_sync = 1'b1;
        m_left   = sample_data;
        m_have_l = 1'b1;
      end else if (!m_have_l) begin
        set_sync = 1'b1;
      end else begin
        if (!full || do_pop) exp_q.push_back({m_left, sample_data});
        else set_ovf = 1'b1;
        m_have_l = 1'b0;
      end
    end
    if (set_sync) m_sync = 1'b1; else if (clear_flags) m_sync = 1'b0;
    if (set_ovf)  m_ovf  = 1'b1; else if (clear_flags) m_ovf  = 1'b0;
  endfunction

  function automatic void check_model();
    logic [2*DS-1:0] head;
    chk("valid", 32'(frame_valid), 32'(exp_q.size() != 0));
    chk("level", 32'(level), 32'(exp_q.size()));
    if (exp_q.size() != 0) begin
      head = exp_q[0];
      chk("head_left", 32'(frame_left), 32'(head[2*DS-1:DS]));
      chk("head_right", 32'(frame_right), 32'(head[DS-1:0]));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("sync_err", 32'(sync_err), 32'(m_sync));
    chk("pair_state", 32'(pair_state), 32'(m_have_l));
  endfunction

  task automatic cyc(input logic sv, input logic ch, input logic [DS-1:0] d,
                     input logic rdy, input logic clr);
    sample_valid = sv;
    sample_ch    = ch;
    sample_data  = d;
    frame_ready  = rdy;
    clear_flags  = clr;
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sample_valid = 1'b0;
    frame_ready  = 1'b0;
    clear_flags  = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;
    check_model();
  endtask

  task automatic send_frame(input logic [DS-1:0] l, input logic [DS-1:0] r, input logic rdy);
    cyc(1'b1, 1'b0, l, rdy, 1'b0);
    cyc(1'b1, 1'b1, r, rdy, 1'b0);
  endtask

  typedef struct {
    logic          sv;
    logic          ch;
    logic [DS-1:0] data;
    logic          rdy;
    logic          clr;
    logic          e_valid;
    logic [4:0]    e_level;
    logic [DS-1:0] e_left;
    logic [DS-1:0] e_right;
    logic          e_sync;
  } vec_t;

  vec_t vecs[12];

  initial begin
    // Basic pair, then the pairing-error sequence.
    vecs[0]  = '{1, 0, 16'h1234, 0, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[1]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[2]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[3]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[4]  = '{1, 1, 16'hABCD, 0, 0, 1, 1, 16'h1234, 16'hABCD, 0};
    vecs[5]  = '{0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0};
    vecs[6]  = '{1, 1, 16'h5555, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
    vecs[7]  = '{1, 0, 16'h0001, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
    vecs[8]  = '{1, 0, 16'h0002, 0, 0, 0, 0, 16'h0000, 16'h0000, 1};
    vecs[9]  = '{1, 1, 16'h0003, 0, 0, 1, 1, 16'h0002, 16'h0003, 1};
    vecs[10] = '{0, 0, 16'h0000, 0, 1, 1, 1, 16'h0002, 16'h0003, 0};
    vecs[11] = '{0, 0, 16'h0000, 1, 0, 0, 0, 16'h0000, 16'h0000, 0};

    model_reset();
    repeat (2) @(posedge clk);
    do_reset();
    chk("rst_valid", 32'(frame_valid), 0);
    chk("rst_level", 32'(level), 0);

    for (int i = 0; i < 12; i++) begin
      cyc(vecs[i].sv, vecs[i].ch, vecs[i].data, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].e_level));
      chk($sformatf("vec%0d_sync", i), 32'(sync_err), 32'(vecs[i].e_sync));
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_left", i), 32'(frame_left), 32'(vecs[i].e_left));
        chk($sformatf("vec%0d_right", i), 32'(frame_right), 32'(vecs[i].e_right));
      end
    end

    // Fill past capacity with no reads: the 17th frame is dropped.
    for (int k = 0; k < 17; k++) begin
      send_frame(DS'(k), DS'(16'h100 + k), 1'b0);
      if (k == 15) chk("fill_no_ovf_yet", 32'(overflow), 0);
    end
    chk("fill_level", 32'(level), 16);
    chk("fill_ovf", 32'(overflow), 1);
    for (int k = 0; k < 16; k++) begin
      chk("drain_left", 32'(frame_left), 32'(k));
      chk("drain_right", 32'(frame_right), 32'(16'h100 + k));
      cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(frame_valid), 0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", 32'(overflow), 0);

    // Full FIFO with a pop in the same cycle as the completing right word.
    for (int k = 0; k < 16; k++) send_frame(DS'(16'h200 + k), DS'(16'h300 + k), 1'b0);
    cyc(1'b1, 1'b0, 16'h2FF, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 16'h3FF, 1'b1, 1'b0);
    chk("fullpop_level", 32'(level), 16);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_head", 32'(frame_left), 32'(16'h201));
    repeat (16) cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("fullpop_empty", 32'(frame_valid), 0);

    // Wrap-around streaming with the consumer always ready.
    for (int k = 0; k < 40; k++) begin
      send_frame(DS'(16'h4000 + k), DS'(16'h8000 + k), 1'b1);
      chk("stream_level_le1", 32'(level <= 1), 1);
    end
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("stream_flags", 32'({overflow, sync_err}), 0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      cyc(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 9) > 4),
          DS'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 40) == 0));
    end

    // Reset mid-operation with frames stored and a left word held.
    do_reset();
    for (int k = 0; k < 5; k++) send_frame(DS'(k + 16'h700), DS'(k + 16'h900), 1'b0);
    cyc(1'b1, 1'b0, 16'h7777, 1'b0, 1'b0);
    chk("pre_rst_level", 32'(level), 5);
    chk("pre_rst_state", 32'(pair_state), 1);
    do_reset();
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_valid", 32'(frame_valid), 0);
    chk("mid_rst_flags", 32'({overflow, sync_err}), 0);
    cyc(1'b1, 1'b1, 16'h1111, 1'b0, 1'b0);
    chk("post_rst_sync", 32'(sync_err), 1);
    chk("post_rst_noframe", 32'(frame_valid), 0);

    sample_valid = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
